// File: rtl/ft2232h_rx_reader.sv
`timescale 1ns / 1ps
// FT2232H FT245 synchronous-FIFO receive engine: drains RXF# data into a show-ahead byte FIFO.
// Define FT_RX_COUNT_EN to compile in the 16-bit captured-byte counter driven on rx_count_o.
module ft2232h_rx_reader #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  adbus_i,
    input  logic        rxf_n_i,
    output logic        oe_n_o,
    output logic        rd_n_o,
    output logic [7:0]  dout_o,
    output logic        dvalid_o,
    input  logic        dready_i,
    output logic [15:0] rx_count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        READ
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] free_next;
    logic          push;
    logic          pop;

    // A byte is on ADBUS for every edge spent in READ while RXF# stays low.
    assign push       = (state == READ) && !rxf_n_i;
    assign pop        = dvalid_o && dready_i;
    assign count_next = count + CW'(push) - CW'(pop);
    assign free_next  = DEPTH_C - count_next;

    // Empty FIFO presents zero so the output is defined without clearing storage.
    assign dout_o = dvalid_o ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dvalid_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            dvalid_o <= (count_next != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= adbus_i;
        end
    end

    // Re-arm only with two free slots: TURN costs a cycle and READ may capture immediately.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            oe_n_o <= 1'b1;
            rd_n_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxf_n_i && (free_next >= CW'(2))) begin
                        state  <= TURN;
                        oe_n_o <= 1'b0;
                    end
                end
                TURN: begin
                    if (!rxf_n_i) begin
                        state  <= READ;
                        rd_n_o <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        oe_n_o <= 1'b1;
                    end
                end
                READ: begin
                    if (rxf_n_i || (free_next < CW'(1))) begin
                        state  <= IDLE;
                        oe_n_o <= 1'b1;
                        rd_n_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    oe_n_o <= 1'b1;
                    rd_n_o <= 1'b1;
                end
            endcase
        end
    end

`ifdef FT_RX_COUNT_EN
    logic [15:0] rx_count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_count <= 16'h0000;
        end else if (push) begin
            rx_count <= rx_count + 16'd1;
        end
    end

    assign rx_count_o = rx_count;
`else
    assign rx_count_o = 16'h0000;
`endif

endmodule

// File: doc/ft2232h_rx_reader.md
# ft2232h_rx_reader

Receive-side engine for the FT2232H in FT245 synchronous FIFO mode. It drains bytes sent by the PC from the FT2232H receive FIFO and presents them to FPGA logic on a valid/ready byte stream. An internal FIFO absorbs the FT2232H read burst. The block runs on the 60 MHz CLKOUT from the FT2232H and sits alongside `ft2232h_count_streamer`, which owns the transmit direction. The top level owns the ADBUS tri-state and direction arbitration.

## Interface
Parameters:
- `DEPTH`, default 4: internal FIFO depth in bytes. Must be a power of 2 and at least 2.

Ports:
- `clk_i`, input, 1: FT2232H CLKOUT (60 MHz). This is the only clock.
- `rst_n_i`, input, 1: synchronous, active-low reset.
- `adbus_i`, input, 8: ADBUS data driven by the FT2232H while `oe_n_o` is low.
- `rxf_n_i`, input, 1: FT2232H RXF#. Low means receive data is available.
- `oe_n_o`, output, 1: FT2232H OE#. Low makes the FT2232H drive ADBUS. The top level also uses it as the bus-direction select.
- `rd_n_o`, output, 1: FT2232H RD#. Low requests a byte on each clock.
- `dout_o`, output, 8: received byte at the head of the FIFO.
- `dvalid_o`, output, 1: `dout_o` is valid.
- `dready_i`, input, 1: the consumer accepts `dout_o`. A pop occurs when `dvalid_o` and `dready_i` are both high.
- `rx_count_o`, output, 16: running count of captured bytes. See Configuration.

## Operation
- FSM states: IDLE, TURN, READ. All outputs are registered.
  - IDLE: `oe_n_o`=1, `rd_n_o`=1.
    - Go to TURN when `rxf_n_i`=0 and free slots ≥ 2, where free slots = `DEPTH` − count_next.
  - TURN: `oe_n_o`=0, `rd_n_o`=1. This is the bus-turnaround cycle.
    - Go to READ if `rxf_n_i`=0, otherwise go to IDLE.
  - READ: `oe_n_o`=0, `rd_n_o`=0.
    - On every edge in READ with `rxf_n_i`=0, capture `adbus_i` into the FIFO.
    - Stay in READ only if `rxf_n_i`=0 and DEPTH − count_next ≥ 1, where count_next includes this edge's push and pop.
    - Otherwise go to IDLE. `oe_n_o` and `rd_n_o` both return high on that same edge.
- No capture happens in IDLE or TURN.
- Each entry into READ passes through TURN. There is always at least one IDLE cycle between bursts.
- FIFO:
  - Show-ahead: `dout_o` = mem[rd_ptr] and `dvalid_o` = (count ≠ 0).
  - A push and a pop on the same edge are both honoured, and the count is unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- Overflow cannot occur by construction. A push never happens when count_next would exceed `DEPTH`.
- `dout_o` holds its value while `dvalid_o`=1 and `dready_i`=0.
- Reset values: `oe_n_o`=1, `rd_n_o`=1, `dvalid_o`=0, `dout_o`=0, `rx_count_o`=0, FSM in IDLE, FIFO empty.
- Reset asserted mid-burst: on the next edge the FIFO is cleared and all outputs take their reset values. A byte on the bus at that edge is discarded.

## Timing
- First-byte latency, with `rxf_n_i` low at edge E0 in IDLE:
  - E0: `oe_n_o` goes low.
  - E1: `rd_n_o` goes low.
  - E2: the first byte is captured, and `dout_o`/`dvalid_o` become valid immediately after E2.
- Sustained throughput is one byte per clock while `rxf_n_i`=0 and the consumer pops every cycle.
- When `rxf_n_i` rises, sampled at edge En: no capture at En, and `rd_n_o` and `oe_n_o` go high after En.
- Backpressure: the edge that fills the FIFO to `DEPTH` also deasserts `rd_n_o` and `oe_n_o`. There is no stall cycle with RD# low.
- After a pop: re-arm needs free ≥ 2, then one IDLE→TURN cycle and one TURN→READ cycle.

## Configuration
- `FT_RX_COUNT_EN` defined:
  - `rx_count_o` increments by 1 on every capture edge.
  - It is 16 bits and wraps from 0xFFFF to 0x0000.
  - It is cleared by reset.
- `FT_RX_COUNT_EN` undefined:
  - The counter logic is not compiled in and `rx_count_o` is tied to 0.

## Test plan
- Reset, with `rst_n_i`=0 for 2 clocks and `rxf_n_i`=0 → `oe_n_o`=1, `rd_n_o`=1, `dvalid_o`=0, `dout_o`=0x00, `rx_count_o`=0.
- Burst of 5 bytes 0x10..0x14, `dready_i`=1, `DEPTH`=4:
  - `oe_n_o` goes low one cycle before `rd_n_o`.
  - `rd_n_o` is low for exactly 5 capture edges.
  - `dout_o` emits 0x10..0x14 in order, with the first byte valid 2 edges after `oe_n_o` falls.
- Backpressure, with `dready_i`=0 and 8 bytes pending:
  - Exactly 4 bytes are captured and `rd_n_o`/`oe_n_o` rise on the 4th capture edge.
  - Then raise `dready_i`=1 → the remaining 4 bytes arrive after a new TURN cycle, with no loss or duplication.
- `rxf_n_i` rises after 2 captured bytes → `rd_n_o`/`oe_n_o` are high on the next edge, only 2 bytes are delivered, and the next burst re-enters through TURN.
- Reset mid-burst after 3 captures with 1 unpopped → FIFO is empty, `dvalid_o`=0, `rd_n_o`=1 and `oe_n_o`=1 on the next edge, and the in-flight byte is not delivered.
- With `FT_RX_COUNT_EN` defined: 300 bytes streamed → `rx_count_o`=300. 65537 bytes streamed → `rx_count_o`=1 (wrapped). Without the macro, `rx_count_o` stays 0.
